// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions used by the write-back stage.
//   - opcode / funct constants for the instructions the W stage decodes
//   - wb_src_e: selects which value is written to the register file
//   - RA_IDX_DEFAULT: link register index written by jal
package mips_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned REG_AW         = 5;
   localparam int unsigned RA_IDX_DEFAULT = 31;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;

   // R-type funct codes
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;
   localparam logic [5:0] FN_SYSCALL = 6'b001100;
   localparam logic [5:0] FN_MFHI    = 6'b010000;
   localparam logic [5:0] FN_MTHI    = 6'b010001;
   localparam logic [5:0] FN_MFLO    = 6'b010010;
   localparam logic [5:0] FN_MTLO    = 6'b010011;
   localparam logic [5:0] FN_MULT    = 6'b011000;
   localparam logic [5:0] FN_MULTU   = 6'b011001;
   localparam logic [5:0] FN_DIV     = 6'b011010;
   localparam logic [5:0] FN_DIVU    = 6'b011011;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_LINK = 2'd2,
      WB_MD   = 2'd3
   } wb_src_e;

endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/halfword of a loaded word and
// sign- or zero-extends it according to the load opcode.
// Ports:
//   dm_w    in  32  aligned word read from data memory
//   addr_lo in  2   low effective-address bits (byte offset)
//   op      in  6   opcode of the W-stage instruction
//   data    out 32  extended load value (dm_w for lw / non-loads)
module load_ext
   import mips_pkg::*;
(
   input  logic [WORD_W-1:0] dm_w,
   input  logic [1:0]        addr_lo,
   input  logic [5:0]        op,
   output logic [WORD_W-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Byte 0 is bits 7:0; halfword choice ignores addr_lo[0]
   always_comb begin
      byte_sel = dm_w[7:0];
      case (addr_lo)
         2'd0:    byte_sel = dm_w[7:0];
         2'd1:    byte_sel = dm_w[15:8];
         2'd2:    byte_sel = dm_w[23:16];
         default: byte_sel = dm_w[31:24];
      endcase
      half_sel = addr_lo[1] ? dm_w[31:16] : dm_w[15:0];
   end

   always_comb begin
      data = dm_w;
      case (op)
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'd0, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'd0, half_sel};
         default: data = dm_w;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back logic.
// Captures the instruction leaving MEM, decodes its destination and
// write-back source, extracts load data and drives the register file
// write port. Also exposes the W-stage instruction, its PC and a
// retired-instruction counter.
// Ports:
//   Clk, reset        clock, synchronous active-high reset
//   stall, flush      hold W stage / load a bubble (flush wins)
//   valid_M, IR_M, PC4_M, ALUOut_M, DMOut_M, MDOut_M   MEM-stage inputs
//   GRF_WE/WA/WD      register file write port (combinational from W regs)
//   PC_W              PC of the W instruction (PC4_W - 4)
//   IR_W              registered instruction for hazard/forward logic
//   retire_cnt        count of retired valid instructions (wraps)
// Optional: define WB_TRACE_EN to print each register file write.
module wb_stage
   import mips_pkg::*;
#(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned RA_IDX = RA_IDX_DEFAULT
)(
   input  logic              Clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_M,
   input  logic [WORD_W-1:0] IR_M,
   input  logic [WORD_W-1:0] PC4_M,
   input  logic [WORD_W-1:0] ALUOut_M,
   input  logic [WORD_W-1:0] DMOut_M,
   input  logic [WORD_W-1:0] MDOut_M,
   output logic              GRF_WE,
   output logic [REG_AW-1:0] GRF_WA,
   output logic [WORD_W-1:0] GRF_WD,
   output logic [WORD_W-1:0] PC_W,
   output logic [WORD_W-1:0] IR_W,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic              v_w;
   logic [WORD_W-1:0] ir_w;
   logic [WORD_W-1:0] pc4_w;
   logic [WORD_W-1:0] alu_w;
   logic [WORD_W-1:0] dm_w;
   logic [WORD_W-1:0] md_w;
   logic [CNT_W-1:0]  cnt_q;

   logic [5:0]        op;
   logic [5:0]        funct;
   logic              writes;
   logic [REG_AW-1:0] wa;
   wb_src_e           src;
   logic [WORD_W-1:0] load_data;
   logic [WORD_W-1:0] wd_raw;
   logic              we;

   // W-stage pipeline register: reset > flush > stall > load
   always_ff @(posedge Clk) begin
      if (reset || flush) begin
         v_w   <= 1'b0;
         ir_w  <= '0;
         pc4_w <= '0;
         alu_w <= '0;
         dm_w  <= '0;
         md_w  <= '0;
      end else if (!stall) begin
         v_w   <= valid_M;
         ir_w  <= IR_M;
         pc4_w <= PC4_M;
         alu_w <= ALUOut_M;
         dm_w  <= DMOut_M;
         md_w  <= MDOut_M;
      end
   end

   // An instruction retires on the edge where it leaves W unstalled
   always_ff @(posedge Clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (v_w && !stall) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Destination and write-back source decode
   always_comb begin
      op     = ir_w[31:26];
      funct  = ir_w[5:0];
      writes = 1'b0;
      wa     = '0;
      src    = WB_ALU;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
               FN_MTHI, FN_MTLO, FN_SYSCALL: begin
                  writes = 1'b0;
               end
               FN_MFHI, FN_MFLO: begin
                  writes = 1'b1;
                  wa     = ir_w[15:11];
                  src    = WB_MD;
               end
               FN_JALR: begin
                  writes = 1'b1;
                  wa     = ir_w[15:11];
                  src    = WB_LINK;
               end
               default: begin
                  writes = 1'b1;
                  wa     = ir_w[15:11];
                  src    = WB_ALU;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            writes = 1'b1;
            wa     = ir_w[20:16];
            src    = WB_ALU;
         end
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
            writes = 1'b1;
            wa     = ir_w[20:16];
            src    = WB_LOAD;
         end
         OP_JAL: begin
            writes = 1'b1;
            wa     = REG_AW'(RA_IDX);
            src    = WB_LINK;
         end
         default: begin
            writes = 1'b0;
         end
      endcase
   end

   load_ext u_load_ext (
      .dm_w    (dm_w),
      .addr_lo (alu_w[1:0]),
      .op      (op),
      .data    (load_data)
   );

   // Write-data select; link address skips the delay slot
   always_comb begin
      wd_raw = alu_w;
      case (src)
         WB_ALU:  wd_raw = alu_w;
         WB_LOAD: wd_raw = load_data;
         WB_LINK: wd_raw = pc4_w + WORD_W'(4);
         WB_MD:   wd_raw = md_w;
         default: wd_raw = alu_w;
      endcase
   end

   // Writes to $0 are suppressed; idle port reads as all zeros
   assign we         = v_w && writes && (wa != '0);
   assign GRF_WE     = we;
   assign GRF_WA     = we ? wa : '0;
   assign GRF_WD     = we ? wd_raw : '0;
   assign PC_W       = pc4_w - WORD_W'(4);
   assign IR_W       = ir_w;
   assign retire_cnt = cnt_q;

`ifdef WB_TRACE_EN
   // Simulation-only write trace
   always @(posedge Clk) begin
      if (GRF_WE && !reset) begin
         $display("%d@%h: $%d <= %h", $time, PC_W, GRF_WA, GRF_WD);
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage. A default-width instance
// and a CNT_W=4 instance share one stimulus stream; expected values come
// from directed constants and a behavioural model of the W stage.
module tb_wb_stage;

   logic        Clk;
   logic        reset, stall, flush, valid_M;
   logic [31:0] IR_M, PC4_M, ALUOut_M, DMOut_M, MDOut_M;
   logic        GRF_WE;
   logic [4:0]  GRF_WA;
   logic [31:0] GRF_WD, PC_W, IR_W, retire_cnt;
   logic        we4;
   logic [4:0]  wa4;
   logic [31:0] wd4, pcw4, irw4;
   logic [3:0]  cnt4;

   int n_cmp = 0;
   int n_err = 0;

   // Model of the W-stage contents and retire count
   logic        m_v;
   logic [31:0] m_ir, m_pc4, m_alu, m_dm, m_md, m_cnt;

   wb_stage dut (
      .Clk(Clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_M(valid_M), .IR_M(IR_M), .PC4_M(PC4_M), .ALUOut_M(ALUOut_M),
      .DMOut_M(DMOut_M), .MDOut_M(MDOut_M),
      .GRF_WE(GRF_WE), .GRF_WA(GRF_WA), .GRF_WD(GRF_WD),
      .PC_W(PC_W), .IR_W(IR_W), .retire_cnt(retire_cnt)
   );

   wb_stage #(.CNT_W(4)) dut4 (
      .Clk(Clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_M(valid_M), .IR_M(IR_M), .PC4_M(PC4_M), .ALUOut_M(ALUOut_M),
      .DMOut_M(DMOut_M), .MDOut_M(MDOut_M),
      .GRF_WE(we4), .GRF_WA(wa4), .GRF_WD(wd4),
      .PC_W(pcw4), .IR_W(irw4), .retire_cnt(cnt4)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Drive one cycle, update the model at the edge, return 1 time unit later
   task automatic step(input logic rst, input logic st, input logic fl, input logic v,
                       input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] md);
      reset = rst; stall = st; flush = fl; valid_M = v;
      IR_M = ir; PC4_M = pc4; ALUOut_M = alu; DMOut_M = dm; MDOut_M = md;
      @(posedge Clk);
      if (rst) begin
         m_cnt = 0;
         m_v = 0; m_ir = 0; m_pc4 = 0; m_alu = 0; m_dm = 0; m_md = 0;
      end else begin
         if (m_v && !st) m_cnt = m_cnt + 1;
         if (fl) begin
            m_v = 0; m_ir = 0; m_pc4 = 0; m_alu = 0; m_dm = 0; m_md = 0;
         end else if (!st) begin
            m_v = v; m_ir = ir; m_pc4 = pc4; m_alu = alu; m_dm = dm; m_md = md;
         end
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   // Expected write port from the instruction semantics
   task automatic model_out(output logic we, output logic [4:0] wa, output logic [31:0] wd);
      logic [5:0]  op, fn;
      logic [7:0]  b;
      logic [15:0] h;
      logic        wr;
      logic [4:0]  d;
      logic [31:0] val;
      op  = m_ir[31:26];
      fn  = m_ir[5:0];
      b   = 8'(m_dm >> (8 * m_alu[1:0]));
      h   = 16'(m_dm >> (16 * m_alu[1]));
      wr  = 0; d = 0; val = 0;
      if (op == 6'h00) begin
         if (fn == 6'h10 || fn == 6'h12) begin
            wr = 1; d = m_ir[15:11]; val = m_md;
         end else if (fn == 6'h09) begin
            wr = 1; d = m_ir[15:11]; val = m_pc4 + 32'd4;
         end else if (!(fn inside {6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13, 6'h0c})) begin
            wr = 1; d = m_ir[15:11]; val = m_alu;
         end
      end else if (op >= 6'h08 && op <= 6'h0f) begin
         wr = 1; d = m_ir[20:16]; val = m_alu;
      end else if (op == 6'h23) begin
         wr = 1; d = m_ir[20:16]; val = m_dm;
      end else if (op == 6'h20) begin
         wr = 1; d = m_ir[20:16]; val = 32'($signed(b));
      end else if (op == 6'h24) begin
         wr = 1; d = m_ir[20:16]; val = {24'd0, b};
      end else if (op == 6'h21) begin
         wr = 1; d = m_ir[20:16]; val = 32'($signed(h));
      end else if (op == 6'h25) begin
         wr = 1; d = m_ir[20:16]; val = {16'd0, h};
      end else if (op == 6'h03) begin
         wr = 1; d = 5'd31; val = m_pc4 + 32'd4;
      end
      we = m_v && wr && (d != 5'd0);
      wa = we ? d : 5'd0;
      wd = we ? val : 32'd0;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 1, 32'h34051234, 32'h1004, 32'h1, 32'h2, 32'h3);
      step(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      n_cmp++;
      if ({GRF_WE, GRF_WA, GRF_WD, retire_cnt, IR_W, PC_W} !==
          {1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFC}) begin
         n_err++;
         $display("FAIL reset_state: got we=%b wa=%0d wd=%h cnt=%0d ir=%h pc=%h expected 0/0/0/0/0/fffffffc",
                  GRF_WE, GRF_WA, GRF_WD, retire_cnt, IR_W, PC_W);
      end
      idle();
      n_cmp++;
      if ({GRF_WE, retire_cnt, IR_W, PC_W, cnt4} !== {1'b0, 32'd0, 32'd0, 32'hFFFFFFFC, 4'd0}) begin
         n_err++;
         $display("FAIL reset_idle: got we=%b cnt=%0d ir=%h pc=%h cnt4=%0d expected 0/0/0/fffffffc/0",
                  GRF_WE, retire_cnt, IR_W, PC_W, cnt4);
      end
   endtask

   task automatic test_ori();
      step(0, 0, 0, 1, 32'h34051234, 32'h3004, 32'h00001234, 32'hAAAA5555, 32'h5555AAAA);
      n_cmp++;
      if ({GRF_WE, GRF_WA, GRF_WD, PC_W, IR_W} !== {1'b1, 5'd5, 32'h00001234, 32'h3000, 32'h34051234}) begin
         n_err++;
         $display("FAIL ori_write: got we=%b wa=%0d wd=%h pc=%h ir=%h expected 1/5/00001234/00003000/34051234",
                  GRF_WE, GRF_WA, GRF_WD, PC_W, IR_W);
      end
      idle();
      n_cmp++;
      if (retire_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL ori_retire: got %0d expected 1", retire_cnt);
      end
   endtask

   task automatic test_loads();
      logic [5:0]  ops  [10] = '{6'h20, 6'h24, 6'h25, 6'h25, 6'h20, 6'h23, 6'h21, 6'h21, 6'h20, 6'h24};
      logic [31:0] alus [10] = '{32'h102, 32'h102, 32'h102, 32'h103, 32'h100, 32'h100,
                                 32'h201, 32'h202, 32'h203, 32'h201};
      logic [31:0] dms  [10] = '{32'h12F45678, 32'h12F45678, 32'h12F45678, 32'h12F45678,
                                 32'h12F45678, 32'h12F45678, 32'h80017FFF, 32'h80017FFF,
                                 32'h80017FFF, 32'h80017FFF};
      logic [31:0] exps [10] = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4, 32'h000012F4,
                                 32'h00000078, 32'h12F45678, 32'h00007FFF, 32'hFFFF8001,
                                 32'hFFFFFF80, 32'h0000007F};
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 1, {ops[i], 5'd1, 5'd8, 16'h0100}, 32'h2004 + 32'(4 * i),
              alus[i], dms[i], 32'h0);
         n_cmp++;
         if ({GRF_WE, GRF_WA, GRF_WD} !== {1'b1, 5'd8, exps[i]}) begin
            n_err++;
            $display("FAIL load[%0d]: got we=%b wa=%0d wd=%h expected 1/8/%h",
                     i, GRF_WE, GRF_WA, GRF_WD, exps[i]);
         end
      end
   endtask

   task automatic test_jal();
      step(0, 0, 0, 1, {6'b000011, 26'h0000C03}, 32'h3010, 32'h0, 32'h0, 32'h0);
      n_cmp++;
      if ({GRF_WE, GRF_WA, GRF_WD, PC_W} !== {1'b1, 5'd31, 32'h00003014, 32'h0000300C}) begin
         n_err++;
         $display("FAIL jal: got we=%b wa=%0d wd=%h pc=%h expected 1/31/00003014/0000300c",
                  GRF_WE, GRF_WA, GRF_WD, PC_W);
      end
      step(0, 0, 0, 1, {6'd0, 5'd4, 5'd0, 5'd0, 5'd0, 6'b001001}, 32'h3020, 32'h77, 32'h0, 32'h0);
      n_cmp++;
      if ({GRF_WE, GRF_WA, GRF_WD} !== {1'b0, 5'd0, 32'd0}) begin
         n_err++;
         $display("FAIL jalr_rd0: got we=%b wa=%0d wd=%h expected 0/0/0", GRF_WE, GRF_WA, GRF_WD);
      end
      step(0, 0, 0, 1, {6'd0, 5'd4, 5'd0, 5'd7, 5'd0, 6'b001001}, 32'hFFFFFFFC, 32'h77, 32'h0, 32'h0);
      n_cmp++;
      if ({GRF_WE, GRF_WA, GRF_WD} !== {1'b1, 5'd7, 32'h00000000}) begin
         n_err++;
         $display("FAIL jalr_wrap: got we=%b wa=%0d wd=%h expected 1/7/00000000", GRF_WE, GRF_WA, GRF_WD);
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] lw3, saved;
      lw3 = {6'b100011, 5'd0, 5'd3, 16'h0010};
      step(0, 0, 0, 1, {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001}, 32'h4004, 32'h99, 32'h0, 32'h0);
      n_cmp++;
      if ({GRF_WE, GRF_WA, GRF_WD} !== {1'b0, 5'd0, 32'd0}) begin
         n_err++;
         $display("FAIL addu_r0: got we=%b wa=%0d wd=%h expected 0/0/0", GRF_WE, GRF_WA, GRF_WD);
      end
      step(0, 0, 0, 1, lw3, 32'h5004, 32'h10, 32'hDEADBEEF, 32'h0);
      saved = m_cnt;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 1, $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
         n_cmp++;
         if ({GRF_WE, GRF_WA, GRF_WD, PC_W, IR_W, retire_cnt} !==
             {1'b1, 5'd3, 32'hDEADBEEF, 32'h5000, lw3, saved}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got we=%b wa=%0d wd=%h pc=%h cnt=%0d expected 1/3/deadbeef/00005000/%0d",
                     i, GRF_WE, GRF_WA, GRF_WD, PC_W, retire_cnt, saved);
         end
      end
      idle();
      n_cmp++;
      if ({GRF_WE, retire_cnt} !== {1'b0, saved + 32'd1}) begin
         n_err++;
         $display("FAIL stall_release: got we=%b cnt=%0d expected 0/%0d", GRF_WE, retire_cnt, saved + 1);
      end
      // flush together with stall: held lw is dropped and not counted
      step(0, 0, 0, 1, lw3, 32'h6004, 32'h10, 32'h01020304, 32'h0);
      saved = m_cnt;
      step(0, 1, 1, 1, 32'h34051234, 32'h7004, 32'h1, 32'h0, 32'h0);
      n_cmp++;
      if ({GRF_WE, IR_W, PC_W, retire_cnt} !== {1'b0, 32'd0, 32'hFFFFFFFC, saved}) begin
         n_err++;
         $display("FAIL flush_stall: got we=%b ir=%h pc=%h cnt=%0d expected 0/0/fffffffc/%0d",
                  GRF_WE, IR_W, PC_W, retire_cnt, saved);
      end
      idle();
      n_cmp++;
      if (retire_cnt !== saved) begin
         n_err++;
         $display("FAIL flush_nocount: got %0d expected %0d", retire_cnt, saved);
      end
      // reset while stalled: reset wins and W becomes a bubble
      step(0, 0, 0, 1, lw3, 32'h8004, 32'h10, 32'h55, 32'h0);
      step(0, 1, 0, 1, lw3, 32'h9004, 32'h10, 32'h66, 32'h0);
      step(1, 1, 0, 1, lw3, 32'hA004, 32'h10, 32'h77, 32'h0);
      n_cmp++;
      if ({GRF_WE, IR_W, PC_W, retire_cnt} !== {1'b0, 32'd0, 32'hFFFFFFFC, 32'd0}) begin
         n_err++;
         $display("FAIL reset_in_stall: got we=%b ir=%h pc=%h cnt=%0d expected 0/0/fffffffc/0",
                  GRF_WE, IR_W, PC_W, retire_cnt);
      end
   endtask

   task automatic test_wrap();
      step(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      for (int i = 0; i < 16; i++)
         step(0, 0, 0, 1, 32'h34061111, 32'h100 + 32'(4 * i), 32'h1111, 32'h0, 32'h0);
      n_cmp++;
      if (cnt4 !== 4'd15) begin
         n_err++;
         $display("FAIL wrap_pre: got cnt4=%0d expected 15", cnt4);
      end
      idle();
      n_cmp++;
      if ({cnt4, retire_cnt} !== {4'd0, 32'd16}) begin
         n_err++;
         $display("FAIL wrap: got cnt4=%0d cnt=%0d expected 0/16", cnt4, retire_cnt);
      end
   endtask

   task automatic test_random();
      logic [5:0]  ops [22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b,
                               6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24,
                               6'h25, 6'h03, 6'h2b, 6'h04, 6'h02, 6'h01};
      logic [31:0] r;
      logic        ewe;
      logic [4:0]  ewa;
      logic [31:0] ewd;
      for (int i = 0; i < 400; i++) begin
         r = $urandom();
         step(($urandom() % 64) == 0, ($urandom() % 6) == 0, ($urandom() % 10) == 0,
              ($urandom() % 4) != 0, {ops[$urandom_range(0, 21)], r[25:0]},
              $urandom(), $urandom(), $urandom(), $urandom());
         model_out(ewe, ewa, ewd);
         n_cmp++;
         if ({GRF_WE, GRF_WA, GRF_WD, we4, wa4, wd4} !== {ewe, ewa, ewd, ewe, ewa, ewd}) begin
            n_err++;
            $display("FAIL rand_grf[%0d]: got we=%b wa=%0d wd=%h expected we=%b wa=%0d wd=%h (ir=%h alu=%h)",
                     i, GRF_WE, GRF_WA, GRF_WD, ewe, ewa, ewd, m_ir, m_alu);
         end
         n_cmp++;
         if ({IR_W, PC_W} !== {m_ir, m_pc4 - 32'd4}) begin
            n_err++;
            $display("FAIL rand_irpc[%0d]: got ir=%h pc=%h expected ir=%h pc=%h",
                     i, IR_W, PC_W, m_ir, m_pc4 - 32'd4);
         end
         n_cmp++;
         if ({retire_cnt, cnt4} !== {m_cnt, 4'(m_cnt)}) begin
            n_err++;
            $display("FAIL rand_cnt[%0d]: got cnt=%0d cnt4=%0d expected %0d/%0d",
                     i, retire_cnt, cnt4, m_cnt, 4'(m_cnt));
         end
      end
   endtask

   initial begin
      m_v = 0; m_ir = 0; m_pc4 = 0; m_alu = 0; m_dm = 0; m_md = 0; m_cnt = 0;
      reset = 1; stall = 0; flush = 0; valid_M = 0;
      IR_M = 0; PC4_M = 0; ALUOut_M = 0; DMOut_M = 0; MDOut_M = 0;
      #2;
      test_reset();
      test_ori();
      test_loads();
      test_jal();
      test_stall_flush();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
